axis_i2c_arbiter: RTL and testbench

Round-robin arbiter that shares the single AXIS-fed I2C write engine (axis_i2c_slave) between N_REQ independent AXI-Stream requesters. It captures one word from the winning requester into a holding register and presents it to the engine's s_axis port. It then enforces a guard interval covering the engine's serial frame before arbitrating again. It sits directly upstream of the engine, between the engine and the register-write sources.

---
 rtl/axis_i2c_pkg.sv | 17 +
 rtl/axis_if.sv | 12 +
 rtl/axis_i2c_rr_picker.sv | 44 ++++
 rtl/axis_i2c_arbiter.sv | 131 +++++++++++++
 tb/tb_axis_i2c_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared types and constants for the AXIS-fed I2C write path and its
// requester arbiter.
package axis_i2c_pkg;

  localparam int AXIS_DATA_WIDTH  = 8;
  localparam int I2C_ARB_N_REQ    = 4;
  localparam int I2C_FRAME_CYCLES = 20;
  localparam int GUARD_CNT_WIDTH  = $clog2(I2C_FRAME_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axis_if.sv
// Single-beat AXI-Stream link used between the arbiter and the I2C engine.
interface axis_if;
  import axis_i2c_pkg::*;

  logic                       tvalid;
  logic                       tready;
  logic [AXIS_DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/axis_i2c_rr_picker.sv
// Combinational round-robin winner search starting at rr_ptr; with prio_en,
// requester 0 pre-empts and the rotation covers only requesters 1..N_REQ-1.
module axis_i2c_rr_picker
  import axis_i2c_pkg::*;
#(
  parameter int N_REQ = I2C_ARB_N_REQ,
  parameter int PTR_W = $clog2(I2C_ARB_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             prio_en,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  logic [N_REQ-1:0] eligible;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    idx        = '0;
    eligible   = req;
    if (prio_en) begin
      eligible[0] = 1'b0;
    end
    if (prio_en && req[0]) begin
      win_onehot[0] = 1'b1;
      win_valid     = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
        if (!win_valid && eligible[idx]) begin
          win_valid       = 1'b1;
          win_onehot[idx] = 1'b1;
          win_idx         = idx;
        end
      end
    end
  end

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter feeding one word at a time from N_REQ AXIS requesters
// into the I2C write engine. Define AXIS_I2C_ARB_PRIO_EN for fixed priority on requester 0.
module axis_i2c_arbiter
  import axis_i2c_pkg::*;
#(
  parameter int N_REQ        = I2C_ARB_N_REQ,
  parameter int GUARD_CYCLES = I2C_FRAME_CYCLES
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic [N_REQ-1:0]                 s_tvalid,
  output logic [N_REQ-1:0]                 s_tready,
  input  logic [N_REQ*AXIS_DATA_WIDTH-1:0] s_tdata,
  axis_if.master                           m_axis,
  output logic [N_REQ-1:0]                 grant,
  output logic                             busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
`ifdef AXIS_I2C_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_t                 state, state_d;
  logic [N_REQ-1:0]           grant_q, grant_d;
  logic [PTR_W-1:0]           idx_q, idx_d;
  logic [PTR_W-1:0]           rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]           cnt, cnt_d;
  logic [AXIS_DATA_WIDTH-1:0] hold, hold_d;

  logic [N_REQ-1:0] win_onehot;
  logic [PTR_W-1:0] win_idx;
  logic             win_valid;

  axis_i2c_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req        (s_tvalid),
    .rr_ptr     (rr_ptr),
    .prio_en    (PRIO_EN),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state   <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      hold    <= '0;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_ptr  <= rr_ptr_d;
      cnt     <= cnt_d;
      hold    <= hold_d;
    end
  end

  // Handshake strobes depend only on registered state/grant, never on inputs.
  always_comb begin
    state_d       = state;
    grant_d       = grant_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr;
    cnt_d         = cnt;
    hold_d        = hold;
    s_tready      = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = hold;

    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_onehot;
          idx_d   = win_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        s_tready = grant_q;
        if (|(s_tvalid & grant_q)) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx_q == PTR_W'(i)) begin
              hold_d = s_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            end
          end
          if (!(PRIO_EN && idx_q == '0)) begin
            rr_ptr_d = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          end
          state_d = SEND;
        end else begin
          // Requester withdrew before its ready pulse: forfeit without rotating.
          grant_d = '0;
          state_d = IDLE;
        end
      end
      SEND: begin
        m_axis.tvalid = 1'b1;
        if (m_axis.tready) begin
          cnt_d   = CNT_W'(GUARD_CYCLES - 1);
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed and randomized bench for axis_i2c_arbiter against a transaction-level
// owner/guard-count model; honours AXIS_I2C_ARB_PRIO_EN like the design.
module tb_axis_i2c_arbiter;
  import axis_i2c_pkg::*;

  localparam int N = 4;
  localparam int G = 20;
  localparam int W = AXIS_DATA_WIDTH;
`ifdef AXIS_I2C_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           arstn;
  logic [N-1:0]   s_tvalid, s_tready, grant;
  logic [N*W-1:0] s_tdata;
  logic           busy;

  axis_if m_if ();

  axis_i2c_arbiter #(
    .N_REQ        (N),
    .GUARD_CYCLES (G)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_axis   (m_if),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // requester and engine environment
  bit         rv[N];
  logic [W-1:0] rd[N];
  bit         stall;
  int         eng_delay;
  int         tv_cnt;

  // reference model: owner index, phase flags, guard cycles remaining
  int         own;
  bit         loading, sending;
  int         glft;
  int         ptr;
  logic [W-1:0] exp_word;

  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];
  int           gseq[$];

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int p);
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (!(PRIO && j == 0) && v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit any_rv();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= rv[i];
    return a;
  endfunction

  function automatic bit in_guard();
    return own >= 0 && !loading && !sending;
  endfunction

  task automatic step();
    bit [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0] eg, sr;
    logic         mv, tr;
    logic [W-1:0] md;
    for (int i = 0; i < N; i++) begin
      v[i] = rv[i];
      d[i*W +: W] = rd[i];
    end
    s_tvalid    = v;
    s_tdata     = d;
    m_if.tready = m_if.tvalid && (tv_cnt >= eng_delay) && !stall;
    #1;
    eg = '0;
    if (own >= 0) eg[own] = 1'b1;
    chk("busy", busy, own >= 0);
    chk("grant", grant, eg);
    chk("s_tready", s_tready, loading ? eg : '0);
    chk("tready_onehot0", $onehot0(s_tready), 1);
    chk("m_tvalid", m_if.tvalid, sending);
    if (sending) chk("m_tdata", m_if.tdata, exp_word);
    sr = s_tready; mv = m_if.tvalid; tr = m_if.tready; md = m_if.tdata;

    if (!arstn) begin
      own = -1; loading = 0; sending = 0; glft = 0; ptr = 0;
    end else if (own < 0) begin
      if (v != '0) begin
        own = pick(v, ptr);
        loading = 1;
      end
    end else if (loading) begin
      loading = 0;
      if (v[own]) begin
        sending  = 1;
        exp_word = rd[own];
        exp_q.push_back(rd[own]);
        if (!(PRIO && own == 0)) ptr = (own + 1) % N;
      end else begin
        own = -1;
      end
    end else if (sending) begin
      if (tr) begin
        sending = 0;
        glft = G;
      end
    end else begin
      glft--;
      if (glft == 0) own = -1;
    end

    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (arstn && rv[i] && sr[i]) begin
        rv[i] = 0;
        gseq.push_back(i);
      end
    end
    if (arstn && mv && tr) begin
      got.push_back(md);
      tv_cnt = 0;
    end else if (mv) begin
      tv_cnt++;
    end else begin
      tv_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) rv[i] = 0;
    stall = 0;
    eng_delay = 1;
    arstn = 0;
    step();
    arstn = 1;
    got.delete();
    exp_q.delete();
    gseq.delete();
  endtask

  // sel: 0 = model in SEND, 1 = model in GUARD, 2 = model idle
  task automatic step_until(input int sel, input int limit, input string tag);
    int  k = 0;
    bit  ok;
    ok = (sel == 0) ? sending : (sel == 1) ? in_guard() : (own < 0);
    while (!ok && k < limit) begin
      step();
      k++;
      ok = (sel == 0) ? sending : (sel == 1) ? in_guard() : (own < 0);
    end
    chk(tag, ok, 1);
  endtask

  task automatic drain(input int limit, input string tag);
    int k = 0;
    while ((own >= 0 || any_rv()) && k < limit) begin
      step();
      k++;
    end
    chk(tag, (own < 0 && !any_rv()), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    own = -1; loading = 0; sending = 0; glft = 0; ptr = 0; exp_word = '0;
    tv_cnt = 0; eng_delay = 1; stall = 0;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rd[i] = '0; end
    s_tvalid = '0; s_tdata = '0; m_if.tready = 1'b0;
    arstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    reset_all();
    chk("reset_rr_ptr", dut.rr_ptr, 0);
    chk("reset_tdata", m_if.tdata, 0);
    chk("reset_tvalid", m_if.tvalid, 0);

    // single requester 2
    rd[2] = 8'hA5; rv[2] = 1;
    step();
    chk("t1_tready", s_tready, 4'b0100);
    drain(100, "t1_drain");
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) chk("t1_word", got[0], 8'hA5);
    chk("t1_rr_ptr", dut.rr_ptr, 3);

    // all four from reset
    reset_all();
    rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33; rd[3] = 8'h44;
    for (int i = 0; i < N; i++) rv[i] = 1;
    drain(400, "t2_drain");
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_word", got[i], 8'h11 * (i + 1));

    // late request during guard, then a competing request in the idle cycle
    reset_all();
    rd[0] = 8'h5A; rv[0] = 1;
    step_until(1, 50, "t3_reach_guard");
    rd[1] = 8'h61; rv[1] = 1;
    step_until(2, 50, "t3_reach_idle");
    rd[3] = 8'h63; rv[3] = 1;
    drain(300, "t3_drain");
    chk("t3_count", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("t3_g0", gseq[0], 0);
      chk("t3_g1", gseq[1], 1);
      chk("t3_g2", gseq[2], 3);
      chk("t3_w1", got[1], 8'h61);
      chk("t3_w2", got[2], 8'h63);
    end

    // engine stall for 50 cycles
    reset_all();
    stall = 1;
    rd[1] = 8'($urandom); rv[1] = 1;
    step_until(0, 20, "t4_reach_send");
    rd[2] = 8'($urandom); rv[2] = 1;
    repeat (50) step();
    chk("t4_one_grant", gseq.size(), 1);
    chk("t4_no_delivery", got.size(), 0);
    stall = 0;
    drain(300, "t4_drain");
    chk("t4_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_w0", got[0], rd[1]);
      chk("t4_w1", got[1], rd[2]);
    end

    // reset while in SEND
    reset_all();
    stall = 1;
    rd[3] = 8'h77; rv[3] = 1;
    step_until(0, 20, "t5_reach_send");
    repeat (2) step();
    arstn = 0;
    step();
    arstn = 1;
    stall = 0;
    chk("t5_grant", grant, 0);
    chk("t5_tvalid", m_if.tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rr_ptr", dut.rr_ptr, 0);
    repeat (30) step();
    chk("t5_discarded", got.size(), 0);

    // requesters 0 and 3 permanently valid
    reset_all();
    for (int k = 0; k < 400 && gseq.size() < 4; k++) begin
      if (!rv[0]) begin rv[0] = 1; rd[0] = 8'($urandom); end
      if (!rv[3]) begin rv[3] = 1; rd[3] = 8'($urandom); end
      step();
    end
    chk("t6_count", gseq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("t6_grant_seq", gseq[i], (PRIO || i % 2 == 0) ? 0 : 3);
    drain(300, "t6_drain");

    // randomized traffic
    reset_all();
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(7) == 0) begin
          rv[i] = 1;
          rd[i] = 8'($urandom);
        end
      end
      if (!m_if.tvalid) eng_delay = $urandom_range(3, 1);
      step();
    end
    drain(600, "t7_drain");
    chk("t7_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("t7_word", got[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
